// File: rtl/dmem_responder.sv
// Word-organised data memory responder for an RV32I load/store port.
// One access at a time: accept, wait WAIT_CYCLES, then a one-cycle response.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_m,
  input  logic        we_m,
  input  logic [2:0]  funct3_m,
  input  logic [31:0] addr_m,
  input  logic [31:0] wdata_m,
  output logic [31:0] rdata_m,
  output logic        ready_m,
  output logic        err_m
);

  // state | meaning
  // IDLE  | ready to accept a request
  // WAIT  | access accepted, counting down wait cycles
  // RESP  | ready_m pulse with err_m/rdata_m; no accept
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_L  = 30'(DEPTH_WORDS);
  localparam logic [2:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept, enter_resp, fault, f3_ok, misalign;
  logic          acc_we;
  logic [2:0]    acc_f3;
  logic [31:0]   acc_addr, acc_wdata;
  logic [AW-1:0] widx;
  logic [31:0]   word, lane, ext, wword;
  logic [3:0]    be;

  always_comb begin
    accept     = (state_q == IDLE) && req_m;
    enter_resp = (accept && (WAIT_CYCLES == 0)) || ((state_q == WAIT) && (cnt_q == 3'd0));
    // With no wait cycles the access completes on its accept edge, before the latches hold it
    acc_we    = accept ? we_m     : we_q;
    acc_f3    = accept ? funct3_m : funct3_q;
    acc_addr  = accept ? addr_m   : addr_q;
    acc_wdata = accept ? wdata_m  : wdata_q;

    case (acc_f3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = !acc_we;
      default:                f3_ok = 1'b0;
    endcase
    case (acc_f3[1:0])
      2'b01:   misalign = acc_addr[0];
      2'b10:   misalign = |acc_addr[1:0];
      default: misalign = 1'b0;
    endcase
    fault = !f3_ok || misalign || (acc_addr[31:2] >= DEPTH_L);

    widx = acc_addr[AW+1:2];
    word = mem[widx];
    lane = word >> {acc_addr[1:0], 3'b000};
    case (acc_f3)
      3'b000:  ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ext = {{16{lane[15]}}, lane[15:0]};
      3'b010:  ext = word;
      3'b100:  ext = {24'd0, lane[7:0]};
      3'b101:  ext = {16'd0, lane[15:0]};
      default: ext = 32'd0;
    endcase
    case (acc_f3[1:0])
      2'b00: begin
        be    = 4'b0001 << acc_addr[1:0];
        wword = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        be    = acc_addr[1] ? 4'b1100 : 4'b0011;
        wword = {2{acc_wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wword = acc_wdata;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ready_d  = 1'b0;
    err_d    = 1'b0;
    rdata_d  = 32'd0;
    case (state_q)
      IDLE: if (req_m) begin
        we_d     = we_m;
        funct3_d = funct3_m;
        addr_d   = addr_m;
        wdata_d  = wdata_m;
        cnt_d    = CNT_INIT;
        state_d  = (WAIT_CYCLES == 0) ? RESP : WAIT;
      end
      WAIT: if (cnt_q == 3'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 3'd1;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      ready_d = 1'b1;
      err_d   = fault;
      if (!acc_we && !fault) rdata_d = ext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
    end
  end

  // Array contents survive reset; a reset edge only suppresses the write
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && acc_we && !fault) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  assign rdata_m = rdata_q;
  assign ready_m = ready_q;
  assign err_m   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: byte-level reference model checked every cycle on
// three instances (WAIT_CYCLES 1, 0, 7) plus directed literal expectations.
module tb_dmem_responder;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a, we_a, req_b, we_b;
  logic [2:0]  f3_a, f3_b;
  logic [31:0] addr_a, wdata_a, addr_b, wdata_b;
  logic [2:0]  rdy_o, err_o;
  logic [2:0][31:0] rd_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit b_hold   = 0;
  int wc[3]      = '{1, 0, 7};
  int gap_exp[3] = '{0, 2, 9};
  int last_rdy[3];
  int pulses[3];

  bit          pending[3];
  logic        p_we[3];
  logic [2:0]  p_f3[3];
  logic [31:0] p_addr[3], p_wd[3];
  int          resp_edge[3], free_edge[3];
  logic        exp_rdy[3], exp_err[3];
  logic [31:0] exp_rd[3];
  logic [7:0]  bmem [longint];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .req_m(req_a), .we_m(we_a), .funct3_m(f3_a),
    .addr_m(addr_a), .wdata_m(wdata_a), .rdata_m(rd_o[0]), .ready_m(rdy_o[0]), .err_m(err_o[0]));

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst), .req_m(req_b), .we_m(we_b), .funct3_m(f3_b),
    .addr_m(addr_b), .wdata_m(wdata_b), .rdata_m(rd_o[1]), .ready_m(rdy_o[1]), .err_m(err_o[1]));

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(7)) dut_w7 (
    .clk(clk), .rst(rst), .req_m(req_b), .we_m(we_b), .funct3_m(f3_b),
    .addr_m(addr_b), .wdata_m(wdata_b), .rdata_m(rd_o[2]), .ready_m(rdy_o[2]), .err_m(err_o[2]));

  function automatic longint key(input int i, input logic [31:0] a);
    return {32'(i), a};
  endfunction

  function automatic logic [7:0] rd_byte(input int i, input logic [31:0] a);
    longint k = key(i, a);
    return bmem.exists(k) ? bmem[k] : 8'h00;
  endfunction

  function automatic bit faults(input logic we, input logic [2:0] f3, input logic [31:0] ad);
    bit legal;
    int nb;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    nb    = 1 << f3[1:0];
    return !legal || ((ad % 32'(nb)) != 0) || ((ad / 32'd4) >= 32'(DEPTH));
  endfunction

  // Accept when idle and past the previous response; respond WAIT edges later.
  task automatic model_step(input int i, input logic rq, input logic we,
                            input logic [2:0] f3, input logic [31:0] ad, input logic [31:0] wd);
    int nb;
    logic [31:0] v;
    exp_rdy[i] = 1'b0;
    exp_err[i] = 1'b0;
    exp_rd[i]  = 32'd0;
    if (rst) begin
      pending[i]   = 1'b0;
      free_edge[i] = cyc + 1;
    end else begin
      if (!pending[i] && rq && cyc >= free_edge[i]) begin
        pending[i]   = 1'b1;
        p_we[i]      = we;
        p_f3[i]      = f3;
        p_addr[i]    = ad;
        p_wd[i]      = wd;
        resp_edge[i] = cyc + wc[i];
        free_edge[i] = cyc + wc[i] + 2;
      end
      if (pending[i] && cyc == resp_edge[i]) begin
        pending[i] = 1'b0;
        exp_rdy[i] = 1'b1;
        if (faults(p_we[i], p_f3[i], p_addr[i])) begin
          exp_err[i] = 1'b1;
        end else begin
          nb = 1 << p_f3[i][1:0];
          if (p_we[i]) begin
            for (int b = 0; b < nb; b++)
              bmem[key(i, p_addr[i] + 32'(b))] = 8'(p_wd[i] >> (8 * b));
          end else begin
            v = 32'd0;
            for (int b = 0; b < nb; b++)
              v |= 32'(rd_byte(i, p_addr[i] + 32'(b))) << (8 * b);
            if (!p_f3[i][2] && nb < 4 && v[8*nb-1]) v |= 32'hFFFF_FFFF << (8 * nb);
            exp_rd[i] = v;
          end
        end
      end
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    model_step(0, req_a, we_a, f3_a, addr_a, wdata_a);
    model_step(1, req_b, we_b, f3_b, addr_b, wdata_b);
    model_step(2, req_b, we_b, f3_b, addr_b, wdata_b);
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (rdy_o[i] !== exp_rdy[i] || err_o[i] !== exp_err[i] || rd_o[i] !== exp_rd[i]) begin
          n_fail++;
          $display("FAIL model_inst%0d cyc=%0d: ready/err/rdata got %0b/%0b/%08h want %0b/%0b/%08h",
                   i, cyc, rdy_o[i], err_o[i], rd_o[i], exp_rdy[i], exp_err[i], exp_rd[i]);
        end
        if (b_hold && i > 0 && rdy_o[i]) begin
          if (last_rdy[i] >= 0) begin
            n_checks++;
            if (cyc - last_rdy[i] != gap_exp[i]) begin
              n_fail++;
              $display("FAIL ready_gap_inst%0d: got %0d want %0d", i, cyc - last_rdy[i], gap_exp[i]);
            end
          end
          last_rdy[i] = cyc;
          pulses[i]++;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h want %08h", nm, act, exp);
    end
  endtask

  // One access on the W=1 instance; inputs are scrambled right after acceptance.
  task automatic run(input string nm, input logic we, input logic [2:0] f3,
                     input logic [31:0] ad, input logic [31:0] wd,
                     input logic [31:0] exp_rd_v, input logic exp_er);
    logic [31:0] rd;
    logic er;
    int lat;
    bit got;
    @(negedge clk);
    req_a = 1'b1; we_a = we; f3_a = f3; addr_a = ad; wdata_a = wd;
    @(posedge clk);
    #1;
    req_a = 1'b0; we_a = ~we; f3_a = 3'b111; addr_a = ad ^ 32'h4; wdata_a = ~wd;
    got = 0; lat = 0; rd = 32'd0; er = 1'b0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      if (rdy_o[0]) begin
        got = 1; lat = k; rd = rd_o[0]; er = err_o[0];
      end
    end
    chk({nm, "_latency"}, 32'(lat), 32'd2);
    chk({nm, "_rdata"}, rd, exp_rd_v);
    chk({nm, "_err"}, 32'(er), 32'(exp_er));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    req_a = 0; we_a = 0; f3_a = 0; addr_a = 0; wdata_a = 0;
    req_b = 0; we_b = 0; f3_b = 0; addr_b = 0; wdata_b = 0;
    for (int i = 0; i < 3; i++) begin last_rdy[i] = -1; pulses[i] = 0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", {29'd0, rdy_o}, 32'd0);
    chk("reset_err", {29'd0, err_o}, 32'd0);
    chk("reset_rdata", rd_o[0], 32'd0);
    rst = 1'b0;

    run("sw_10",  1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
    run("lw_10",  1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    run("sb_11",  1'b1, 3'b000, 32'h11, 32'h0000_007F, 32'h0, 1'b0);
    run("lb_11",  1'b0, 3'b000, 32'h11, 32'h0, 32'h0000_007F, 1'b0);
    run("lbu_13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h0000_00DE, 1'b0);
    run("lh_12",  1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF_DEAD, 1'b0);
    run("sh_12",  1'b1, 3'b001, 32'h12, 32'h1234_BEEF, 32'h0, 1'b0);
    run("lw_10b", 1'b0, 3'b010, 32'h10, 32'h0, 32'hBEEF_7FEF, 1'b0);
    run("lhu_12", 1'b0, 3'b101, 32'h12, 32'h0, 32'h0000_BEEF, 1'b0);

    run("sw_20",      1'b1, 3'b010, 32'h20, 32'h0BAD_F00D, 32'h0, 1'b0);
    run("lh_21_mis",  1'b0, 3'b001, 32'h21, 32'h0, 32'h0, 1'b1);
    run("sw_22_mis",  1'b1, 3'b010, 32'h22, 32'hFFFF_FFFF, 32'h0, 1'b1);
    run("lw_oob",     1'b0, 3'b010, 32'(DEPTH * 4), 32'h0, 32'h0, 1'b1);
    run("ld_f3_011",  1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 1'b1);
    run("st_f3_100",  1'b1, 3'b100, 32'h20, 32'hFFFF_FFFF, 32'h0, 1'b1);
    run("lw_20",      1'b0, 3'b010, 32'h20, 32'h0, 32'h0BAD_F00D, 1'b0);

    run("sw_30_old", 1'b1, 3'b010, 32'h30, 32'hCAFE_F00D, 32'h0, 1'b0);
    @(negedge clk);
    req_a = 1'b1; we_a = 1'b1; f3_a = 3'b010; addr_a = 32'h30; wdata_a = 32'h1234_5678;
    @(posedge clk);
    #1 req_a = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_wait_ready", 32'(rdy_o[0]), 32'd0);
      chk("rst_wait_err", 32'(err_o[0]), 32'd0);
      chk("rst_wait_rdata", rd_o[0], 32'd0);
    end
    run("lw_30", 1'b0, 3'b010, 32'h30, 32'h0, 32'hCAFE_F00D, 1'b0);

    run("sw_44_pre", 1'b1, 3'b010, 32'h44, 32'h5555_AAAA, 32'h0, 1'b0);
    run("sw_40",     1'b1, 3'b010, 32'h40, 32'hA5A5_A5A5, 32'h0, 1'b0);
    run("lw_40",     1'b0, 3'b010, 32'h40, 32'h0, 32'hA5A5_A5A5, 1'b0);
    run("lw_44",     1'b0, 3'b010, 32'h44, 32'h0, 32'h5555_AAAA, 1'b0);

    @(negedge clk);
    b_hold = 1;
    req_b = 1'b1; we_b = 1'b1; f3_b = 3'b010; addr_b = 32'h8; wdata_b = 32'h00C0_FFEE;
    repeat (40) @(negedge clk);
    we_b = 1'b0;
    repeat (40) @(negedge clk);
    b_hold = 0;
    req_b = 1'b0;
    chk("pulses_w0", 32'(pulses[1] >= 39), 32'd1);
    chk("pulses_w7", 32'(pulses[2] >= 8), 32'd1);
    repeat (12) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words in the data array.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, range 0..7, meaning the number of extra wait cycles per access.
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, meaning reset; it is synchronous and active-high.
REQ-005 SHALL have port req_m, input, 1 bit, meaning the initiator requests an access.
REQ-006 SHALL have port we_m, input, 1 bit, meaning 1 = store, 0 = load.
REQ-007 SHALL have port funct3_m, input, 3 bits, meaning the RV32I load/store size and sign code.
REQ-008 SHALL have port addr_m, input, 32 bits, meaning the byte address.
REQ-009 SHALL have port wdata_m, input, 32 bits, meaning the store data, right-aligned.
REQ-010 SHALL have port rdata_m, output, 32 bits, meaning the extended load result.
REQ-011 SHALL have port ready_m, output, 1 bit, meaning a one-cycle completion pulse.
REQ-012 SHALL have port err_m, output, 1 bit, meaning the completed access faulted; valid only while ready_m = 1.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-014 IDLE with req_m = 1 SHALL latch we/funct3/addr/wdata; go to WAIT if WAIT_CYCLES > 0, else directly to RESP.
REQ-015 Inputs changing after acceptance SHALL be ignored until the next acceptance.
REQ-016 WAIT SHALL count down a 3-bit counter loaded with WAIT_CYCLES-1 and go to RESP on the edge where the counter equals 0.
REQ-017 RESP SHALL assert ready_m = 1 for exactly one cycle, then return to IDLE; no request SHALL be accepted in RESP.
REQ-018 Access latency, from the accept edge to ready_m high, SHALL be WAIT_CYCLES+1 cycles.
REQ-019 Back-to-back throughput SHALL be one access per WAIT_CYCLES+2 cycles.
REQ-020 Fault conditions SHALL be any of:
  - funct3 illegal for the direction (load: 011, 110, 111; store: anything other than 000/001/010);
  - halfword with addr[0] = 1;
  - word with addr[1:0] != 0;
  - addr[31:2] >= DEPTH_WORDS.
REQ-021 A faulted access SHALL still traverse WAIT and RESP with full latency, assert err_m = 1 in RESP, drive rdata_m = 0, and never modify the array.
REQ-022 A non-faulted store SHALL write the array on the edge entering RESP.
  - sb: byte lane addr[1:0] ← wdata[7:0].
  - sh: lanes addr[1]*2 +1:0 ← wdata[15:0].
  - sw: all four lanes.
  - Other lanes SHALL be unchanged.
REQ-023 A non-faulted load SHALL register the word on the edge entering RESP and present it extended on rdata_m during RESP.
  - lb (000) / lh (001): sign-extend.
  - lw (010): whole word.
  - lbu (100) / lhu (101): zero-extend.
  - Extension SHALL use the selected lane.
REQ-024 rdata_m SHALL be 0 during stores and in every non-RESP cycle; err_m SHALL be 0 outside RESP.
REQ-025 A load immediately following a store to the same address SHALL return the newly stored data.

Reset
REQ-026 rst = 1 SHALL, on the next edge, force IDLE, counter = 0, ready_m = 0, err_m = 0, rdata_m = 0, and clear latched request fields; rst SHALL have priority over all other inputs.
REQ-027 Reset asserted during WAIT SHALL abandon the pending access; a pending store SHALL NOT be written.
REQ-028 Array contents SHALL NOT be reset; after rst deasserts, the first accept SHALL occur no earlier than the following edge.

Verification
REQ-029 Bench SHALL cover, with WAIT_CYCLES = 1: sw 0xDEADBEEF @0x10, then lw @0x10 -> ready_m high 2 cycles after each accept, rdata_m = 0xDEADBEEF, err_m = 0.
REQ-030 Bench SHALL cover: sb 0x7F @0x11, then lb @0x11, lbu @0x13, lh @0x12 -> rdata_m = 0x0000007F, 0x000000DE, 0xFFFFDEAD respectively.
REQ-031 Bench SHALL cover: lh @0x21, sw @0x22, lw @(DEPTH_WORDS*4), load funct3 = 011 -> each ready_m with err_m = 1, rdata_m = 0; a subsequent lw @0x20 returns the prior contents.
REQ-032 Bench SHALL cover: sw 0x12345678 @0x30 with rst pulsed in the WAIT cycle -> no ready_m, ready_m/err_m/rdata_m = 0; a later lw @0x30 returns the old value.
REQ-033 Bench SHALL cover: WAIT_CYCLES = 0 and 7 with req_m held high continuously -> ready_m pulses every 2 and every 9 cycles respectively, never two consecutive cycles high.
REQ-034 Bench SHALL cover: change addr_m/wdata_m during WAIT after accepting sw 0xA5A5A5A5 @0x40 -> 0x40 holds 0xA5A5A5A5 and the new address is untouched.
